// File: rtl/fb_pixel_source_if.sv
// fb_pixel_source_if
// Back-bank write port of the pixel source: game logic (master) pushes one
// RGB332 pixel per handshake, the framebuffer (slave) raises wr_ready when
// it can take it.
//   wr_valid  master -> slave  write request
//   wr_ready  slave  -> master write accepted when wr_valid & wr_ready
//   wr_x      master -> slave  framebuffer column (0..FB_W-1 is in range)
//   wr_y      master -> slave  framebuffer row    (0..FB_H-1 is in range)
//   wr_color  master -> slave  RGB332 colour
interface fb_pixel_source_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_x;
    logic [6:0] wr_y;
    logic [7:0] wr_color;

    modport master (output wr_valid, wr_x, wr_y, wr_color, input wr_ready);
    modport slave  (input wr_valid, wr_x, wr_y, wr_color, output wr_ready);
endinterface

// File: rtl/fb_pixel_source.sv
// fb_pixel_source
// Double-buffered low-resolution RGB332 framebuffer sitting directly upstream
// of the VGA timing stage. The front bank is scanned out using the timing
// stage's next_x/next_y request (2-cycle latency, upscaled by 2^SCALE_SHIFT);
// game logic draws into the back bank through the write interface. Bank swap
// (and optional back-bank clear) is sequenced by a small FSM that waits for
// the frame boundary (next_y returning to 0).
//
// Ports:
//   CLOCK_25     pixel clock, shared with the timing stage
//   reset        synchronous, active-high
//   next_x/y     requested screen column/row
//   wr           back-bank write port (slave side of fb_pixel_source_if)
//   swap_req     pulse: swap banks at next frame boundary
//   clear_req    pulse: fill back bank with clear_color (FB_CLEAR_EN only)
//   clear_color  RGB332 fill value, sampled with clear_req
//   swap_done    one-cycle pulse when the swap takes effect
//   R/G/B_out    expanded 8-bit colour to the timing stage
//
// Build option: define FB_CLEAR_EN to include the clear engine (CLEAR state,
// clear counter, clear colour path). Without it clear_req/clear_color are
// ignored.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | write port open; waiting for clear or swap request
// CLEAR     | writing clear colour to every back-bank pixel, port closed
// WAIT_SWAP | swap requested; port closed until the next frame boundary
module fb_pixel_source #(
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int SCALE_SHIFT = 2
) (
    input  logic             CLOCK_25,
    input  logic             reset,
    input  logic [9:0]       next_x,
    input  logic [9:0]       next_y,
    fb_pixel_source_if.slave wr,
    input  logic             swap_req,
    input  logic             clear_req,
    input  logic [7:0]       clear_color,
    output logic             swap_done,
    output logic [7:0]       R_out,
    output logic [7:0]       G_out,
    output logic [7:0]       B_out
);
    localparam int DEPTH = FB_W * FB_H;
    localparam int AW    = $clog2(2 * DEPTH);
    localparam logic [AW-1:0] W_A     = AW'(FB_W);
    localparam logic [AW-1:0] H_A     = AW'(FB_H);
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

`ifdef FB_CLEAR_EN
    localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);
    typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, WAIT_SWAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_SWAP = 2'd2} state_t;
`endif

    // Both banks live in one array: bank b occupies [b*DEPTH, (b+1)*DEPTH).
    logic [7:0]    mem [0:2*DEPTH-1];

    state_t        state;
    logic          front_q;
    logic          ready_q;
    logic [9:0]    prev_y_q;
    logic          frame_bound;
    logic          swap_now;

    logic [AW-1:0] fx, fy;
    logic          rd_oob, rd_oob_q, rd_bank;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;

    logic          wr_fire, wr_in;
    logic [AW-1:0] back_base, wr_addr;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

`ifdef FB_CLEAR_EN
    logic [AW-1:0] clr_cnt;
    logic [7:0]    clr_color_q;
    logic          swap_pend;
`else
    logic          unused_clear;
    assign unused_clear = ^{clear_req, clear_color};
`endif

    assign frame_bound = (next_y == 10'd0) && (prev_y_q != 10'd0);
    // A swap landing on this cycle already redirects this cycle's read.
    assign swap_now    = (state == WAIT_SWAP) && frame_bound && !reset;

    // Read address (cycle N)
    assign fx      = AW'(next_x >> SCALE_SHIFT);
    assign fy      = AW'(next_y >> SCALE_SHIFT);
    assign rd_oob  = (fx >= W_A) || (fy >= H_A);
    assign rd_bank = front_q ^ swap_now;
    assign rd_addr = rd_oob ? '0 : ((rd_bank ? DEPTH_A : '0) + fy * W_A + fx);

    // ready_q holds the post-reset value so the port opens on the very first
    // cycle after reset; the gate keeps it closed while reset is asserted.
    assign wr.wr_ready = ready_q && !reset;
    assign wr_fire     = wr.wr_valid && wr.wr_ready;
    assign wr_in       = (AW'(wr.wr_x) < W_A) && (AW'(wr.wr_y) < H_A);
    assign back_base   = front_q ? '0 : DEPTH_A;
    assign wr_addr     = AW'(wr.wr_y) * W_A + AW'(wr.wr_x);

`ifdef FB_CLEAR_EN
    assign mem_we    = ((state == CLEAR) && !reset) || (wr_fire && wr_in);
    assign mem_waddr = back_base + ((state == CLEAR) ? clr_cnt : wr_addr);
    assign mem_wdata = (state == CLEAR) ? clr_color_q : wr.wr_color;
`else
    assign mem_we    = wr_fire && wr_in;
    assign mem_waddr = back_base + wr_addr;
    assign mem_wdata = wr.wr_color;
`endif

    // Frame buffer RAM: one write port (back bank), one read port (front bank)
    always_ff @(posedge CLOCK_25) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
        rd_data <= mem[rd_addr];
    end

    // RGB332 expansion by bit replication (cycle N+2)
    always_ff @(posedge CLOCK_25) begin
        rd_oob_q <= rd_oob;
        if (reset) begin
            R_out <= 8'd0;
            G_out <= 8'd0;
            B_out <= 8'd0;
        end else if (rd_oob_q) begin
            R_out <= 8'd0;
            G_out <= 8'd0;
            B_out <= 8'd0;
        end else begin
            R_out <= {rd_data[7:5], rd_data[7:5], rd_data[7:6]};
            G_out <= {rd_data[4:2], rd_data[4:2], rd_data[4:3]};
            B_out <= {rd_data[1:0], rd_data[1:0], rd_data[1:0], rd_data[1:0]};
        end
    end

    // Sequencing FSM
    always_ff @(posedge CLOCK_25) begin
        prev_y_q <= next_y;
        if (reset) begin
            state     <= IDLE;
            front_q   <= 1'b0;
            ready_q   <= 1'b1;
            swap_done <= 1'b0;
`ifdef FB_CLEAR_EN
            swap_pend   <= 1'b0;
            clr_cnt     <= '0;
            clr_color_q <= 8'd0;
`endif
        end else begin
            swap_done <= 1'b0;
            case (state)
                IDLE: begin
`ifdef FB_CLEAR_EN
                    if (clear_req) begin
                        state       <= CLEAR;
                        clr_cnt     <= '0;
                        clr_color_q <= clear_color;
                        swap_pend   <= swap_req;
                        ready_q     <= 1'b0;
                    end else if (swap_req) begin
                        state   <= WAIT_SWAP;
                        ready_q <= 1'b0;
                    end
`else
                    if (swap_req) begin
                        state   <= WAIT_SWAP;
                        ready_q <= 1'b0;
                    end
`endif
                end
`ifdef FB_CLEAR_EN
                CLEAR: begin
                    if (swap_req)
                        swap_pend <= 1'b1;
                    if (clr_cnt == LAST_A) begin
                        swap_pend <= 1'b0;
                        if (swap_pend || swap_req) begin
                            state <= WAIT_SWAP;
                        end else begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
`endif
                WAIT_SWAP: begin
                    if (frame_bound) begin
                        front_q   <= ~front_q;
                        swap_done <= 1'b1;
                        state     <= IDLE;
                        ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule
